// File: rtl/picmicro_pkg.sv
// Shared constants and types for the midrange core fetch stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package picmicro_pkg;

    localparam int PC_WIDTH        = 13;
    localparam int INSTR_WIDTH     = 14;
    localparam int FLUSH_CNT_WIDTH = 16;

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 14'h0000;

    // Q1..Q4 of the instruction cycle, encoded 0..3 on q_out.
    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_t;

    // Next phase, wrapping Q4 back to Q1.
    function automatic q_phase_t q_next(q_phase_t q);
        logic [1:0] nxt;
        nxt = q + 2'd1;
        return q_phase_t'(nxt);
    endfunction

endpackage

// File: rtl/picmicro_fetch_unit_if.sv
// Fetch-stage bus: pc/progmem side, control flush/hold, execute-side instruction.
// Latency: n/a (wiring only).
// Backpressure: hold is the only stall; it freezes the whole fetch stage.
// flush_count exists only when FETCH_FLUSH_STATS_EN is defined.
interface picmicro_fetch_unit_if;
    import picmicro_pkg::*;

    logic                   hold;
    logic [PC_WIDTH-1:0]    pc_in;
    logic [PC_WIDTH-1:0]    progmem_addr;
    logic [INSTR_WIDTH-1:0] progmem_data;
    logic                   instr_flush;
    logic [1:0]             q_out;
    logic                   pc_inc_en;
    logic [INSTR_WIDTH-1:0] instr_current;
    logic                   instr_flushed;
`ifdef FETCH_FLUSH_STATS_EN
    logic [FLUSH_CNT_WIDTH-1:0] flush_count;
`endif

    // Environment side: pc module, program memory, control, execute.
    modport master (
        output hold, pc_in, progmem_data, instr_flush,
        input  progmem_addr, q_out, pc_inc_en, instr_current, instr_flushed
`ifdef FETCH_FLUSH_STATS_EN
        , input flush_count
`endif
    );

    // Fetch unit side.
    modport slave (
        input  hold, pc_in, progmem_data, instr_flush,
        output progmem_addr, q_out, pc_inc_en, instr_current, instr_flushed
`ifdef FETCH_FLUSH_STATS_EN
        , output flush_count
`endif
    );

endinterface

// File: rtl/picmicro_q_sequencer.sv
// Q-phase generator: 2-bit phase counter plus fetch (q==1) and latch (q==3) strobes.
// Latency: phase advances one step per clk; strobes are combinational from the phase.
// Backpressure: hold_i freezes the phase and suppresses both strobes.
module picmicro_q_sequencer
    import picmicro_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     hold_i,
    output q_phase_t q_o,
    output logic     fetch_stb_o,
    output logic     latch_stb_o
);

    q_phase_t q_q;
    q_phase_t q_d;

    // Next phase: wrap 3->0, stay put while held.
    always_comb begin
        q_d = hold_i ? q_q : q_next(q_q);
    end

    // Phase register; reset wins over hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= Q1;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o         = q_q;
    assign fetch_stb_o = (q_q == Q2) && !hold_i;
    assign latch_stb_o = (q_q == Q4) && !hold_i;

endmodule

// File: rtl/picmicro_fetch_unit.sv
// Instruction fetch: prefetches progmem at q==1, hands it to execute at q==3, injects NOP on flush.
// Latency: word at pc_in in cycle N becomes instr_current at the end of cycle N (executes in N+1).
// Backpressure: hold freezes all state and drops pc_inc_en; optional flush_count under FETCH_FLUSH_STATS_EN.
module picmicro_fetch_unit
    import picmicro_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    picmicro_fetch_unit_if.slave bus
);

    q_phase_t q;
    logic     fetch_stb;
    logic     latch_stb;

    logic [INSTR_WIDTH-1:0] fetch_q,   fetch_d;
    logic [INSTR_WIDTH-1:0] instr_q,   instr_d;
    logic                   flushed_q, flushed_d;
    logic                   pend_q,    pend_d;
    logic                   flush_now;

    picmicro_q_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .hold_i      (bus.hold),
        .q_o         (q),
        .fetch_stb_o (fetch_stb),
        .latch_stb_o (latch_stb)
    );

    // A flush arriving in the same clk as the Q3 edge counts for this hand-off.
    assign flush_now = bus.instr_flush || pend_q;

    // Next-state for the prefetch, execute and pending-flush registers.
    always_comb begin
        fetch_d   = fetch_q;
        instr_d   = instr_q;
        flushed_d = flushed_q;
        pend_d    = pend_q;
        if (fetch_stb) begin
            fetch_d = bus.progmem_data;
        end
        if (latch_stb) begin
            instr_d   = flush_now ? NOP_WORD : fetch_q;
            flushed_d = flush_now;
            pend_d    = 1'b0;
        end else if (bus.instr_flush) begin
            // Not a Q3 hand-off (other phase, or held): remember it for the next one.
            pend_d = 1'b1;
        end
    end

    // Pipeline registers; reset discards any in-flight fetch and pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q   <= NOP_WORD;
            instr_q   <= NOP_WORD;
            flushed_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            fetch_q   <= fetch_d;
            instr_q   <= instr_d;
            flushed_q <= flushed_d;
            pend_q    <= pend_d;
        end
    end

`ifdef FETCH_FLUSH_STATS_EN
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_q;

    // Count injected NOPs, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (latch_stb && flush_now && (flush_cnt_q != {FLUSH_CNT_WIDTH{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.flush_count = flush_cnt_q;
`endif

    assign bus.progmem_addr  = bus.pc_in;
    assign bus.q_out         = q;
    assign bus.pc_inc_en     = latch_stb;
    assign bus.instr_current = instr_q;
    assign bus.instr_flushed = flushed_q;

endmodule

// File: doc/picmicro_fetch_unit.md
Name: picmicro_fetch_unit

Overview:
Instruction fetch stage of the midrange core, directly upstream of execute/control. It generates the 4-clock Q-phase instruction cycle and drives the program memory address from the PC. It prefetches the next instruction word and presents instr_current to execute. On a flush (goto/call/return/retlw/skip) it substitutes a NOP (14'h0000) so the instruction after a branch never executes.

Parameters:
PC_WIDTH, 13, program counter / program memory address width
INSTR_WIDTH, 14, instruction word width
NOP_WORD, 14'h0000, word injected on flush and at reset

Ports:
clk  input  1  core clock, rising-edge
rst  input  1  synchronous, active-high reset
hold  input  1  freeze the Q sequencer and all registers (sleep/debug halt)
pc_in  input  PC_WIDTH  current PC from the pc module
progmem_addr  output  PC_WIDTH  program memory read address
progmem_data  input  INSTR_WIDTH  program memory read data, valid 1 clk after address
instr_flush  input  1  control request: discard the prefetched word
q_out  output  2  current Q phase, 0..3
pc_inc_en  output  1  one-clk pulse telling the pc module to advance
instr_current  output  INSTR_WIDTH  instruction word in execute
instr_flushed  output  1  instr_current is an injected NOP

Behaviour:
- Reset values: q_out=0, instr_current=NOP_WORD, instr_flushed=0, internal fetch_reg=NOP_WORD, flush_pending=0. rst overrides hold.
- Q sequencer: q increments every clk when !hold, wraps 3->0. One instruction cycle = 4 clks.
- progmem_addr = pc_in, combinational. The pc module keeps pc_in stable from Q0 to Q3.
- Q1 edge (clk edge while q==1, !hold): fetch_reg <= progmem_data.
- pc_inc_en = (q==3) && !hold, combinational. The pc module applies jump/call/pop in place of the increment when its own enables are set.
- Q3 edge (q==3, !hold):
  - If instr_flush || flush_pending: instr_current <= NOP_WORD and instr_flushed <= 1.
  - Otherwise: instr_current <= fetch_reg and instr_flushed <= 0.
  - flush_pending <= 0 in both cases.
- instr_flush sampled at any Q phase: flush_pending is set at the edge where instr_flush=1 and q!=3. A single-clk pulse anywhere in a cycle therefore flushes exactly the next instruction. Flush during hold is still latched.
- Pipeline latency: the word at address A is fetched in cycle N and becomes instr_current at the end of cycle N, so it executes during cycle N+1.
- After reset deassertion: cycle 0 fetches address 0 and executes NOP. Cycle 1 executes word 0.
- Back-to-back flushes (branch target is itself a branch): each flush injects exactly one NOP. No accumulation.
- Hold: q, fetch_reg, instr_current and flush_pending are frozen. pc_inc_en=0. Release resumes at the same Q phase.
- Reset mid-cycle: all state returns to reset values on the next edge. The in-flight fetch is discarded.

Optional Feature:
FETCH_FLUSH_STATS_EN
- Defined: adds output flush_count [15:0]. It increments (saturating at 16'hFFFF) at every Q3 edge that injects a flush NOP, and resets to 0.
- Undefined: the port and counter are absent. No other behaviour changes.

Decomposition:
- Shared package picmicro_pkg: PC_WIDTH/INSTR_WIDTH constants, NOP_WORD, q_phase_t enum (Q1..Q4 encoded 0..3).
- One natural sub-module, picmicro_q_sequencer: 2-bit counter with hold, plus the q==1 and q==3 strobes. Everything else stays in picmicro_fetch_unit.

Test Plan:
1. Reset held 2 clks, then released with progmem[0]=14'h3005 (movlw 0x05) -> q_out 0,1,2,3,0; instr_current=0 during cycle 0; 14'h3005 during cycle 1; pc_inc_en pulses once per 4 clks.
2. goto 0x50 at address 0: pulse instr_flush at q=2 of its execute cycle -> next instr_current=14'h0000 with instr_flushed=1; the following cycle presents progmem[0x50].
3. call then immediate return (flush in two consecutive cycles) -> exactly two NOPs, no third; the instruction at the return address executes in the next cycle.
4. hold asserted at q=2 for 10 clks -> q_out stays 2, instr_current unchanged, pc_inc_en=0; after release q advances 2->3->0 and the pipeline resumes correctly.
5. rst asserted at q=1 with flush_pending=1 -> next edge: q_out=0, instr_current=0, instr_flushed=0; first post-reset instruction is not spuriously flushed.
6. With FETCH_FLUSH_STATS_EN: 3 flushes over 10 cycles -> flush_count=3; rst -> flush_count=0.
